// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, with start/busy/done framing.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  // Encoding chosen so busy and done come straight from state flops.
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b10} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic [CW-1:0] cnt;
  logic br, d, br_n, last, accept;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;
`endif
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_n   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = cnt == CW'(WIDTH - 1);
  assign r_next = {d, r_sr[WIDTH-1:1]};
  assign accept = state != S_SHIFT && start;
  assign busy   = state[0];
  assign done   = state[1];
  always_comb begin
    next = state;
    next = state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : (start ? S_SHIFT : S_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      state <= next;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        r_sr <= '0;
        cnt  <= '0;
        br   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == S_SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_next;
        cnt  <= cnt + CW'(1);
        br   <= br_n;
        if (last) begin
          diff       <= r_next;
          borrow_out <= br_n;
`ifdef SERIAL_SUB_OVERFLOW_EN
          overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
        end
      end
    end
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a single borrow flip-flop carried between cycles. It is the inverse-direction companion to the team's combinational adder cells: it trades latency for area in datapaths where a WIDTH-bit parallel subtractor is too large. A start/busy/done handshake frames each operation, and the result is held stable until the next accepted start.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥ 2)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  request; sampled high in IDLE or DONE launches an operation
- `a`  input  WIDTH  minuend, captured on the accepting edge
- `b`  input  WIDTH  subtrahend, captured on the accepting edge
- `busy`  output  1  high while bits are being processed
- `done`  output  1  one-cycle pulse when `diff` becomes valid
- `diff`  output  WIDTH  result `a - b` mod 2^WIDTH
- `borrow_out`  output  1  final borrow (1 ⇔ unsigned a < b)
- `overflow`  output  1  signed overflow (present only with macro, see Configuration)

## Operation
- Single clock, `clk`; reset is asynchronous and active-low on `rst_n`.
- FSM states:
  - IDLE: `busy`=0, `done`=0. `start`=1 → capture `a`,`b` into shift registers, clear borrow, clear bit counter → SHIFT.
  - SHIFT: `busy`=1. Each cycle, with x=a_sr[0], y=b_sr[0], br=borrow:
    - d = x^y^br
    - br' = (~x&y) | (~(x^y)&br)
    - d enters the MSB of the result register, which shifts right
    - a_sr and b_sr shift right; the counter increments
    - After the WIDTH-th bit → DONE.
  - DONE: `busy`=0, `done`=1 for exactly one cycle. `diff` and `borrow_out` are updated and stay valid. `start`=1 → restart as from IDLE (back-to-back); else → IDLE.
- `start` during SHIFT is ignored; operands are not re-captured.
- `diff`/`borrow_out` hold their last value in IDLE and through the entire next operation; they change only on entry to DONE.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH+1)) bits wide.
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0, internal registers 0.
- Reset asserted mid-operation aborts immediately. Outputs go to reset values and no `done` is produced.

## Timing
- Edge E0 samples `start`=1 (IDLE/DONE). `busy`=1 from E0 through E(WIDTH); `done`=1 for the cycle after E(WIDTH).
- Latency from accepting edge to `done` rising: WIDTH+1 edges. Throughput: one result per WIDTH+1 cycles with back-to-back start.
- `a`/`b` need to be stable only at the accepting edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - Port `overflow` exists.
  - Updated with `diff` on entry to DONE: overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs (registered at start).
  - Reset value 0; holds like `diff`.
- Undefined: port and related registers are absent; all other behaviour is identical.

## Test plan
- WIDTH=8. Apply a=0x5A, b=0x3C, pulse `start` → `busy` for 8 cycles, then `done` pulse with `diff`=0x1E, `borrow_out`=0 (`overflow`=0).
- a=0x00, b=0x01 → `diff`=0xFF, `borrow_out`=1; a=0x80, b=0x80 → `diff`=0x00, `borrow_out`=0.
- With macro: a=0x80, b=0x01 → `diff`=0x7F, `overflow`=1, `borrow_out`=0. Then a=0x7F, b=0xFF → `diff`=0x80, `overflow`=1, `borrow_out`=1.
- Start 0x10-0x01. Assert `start` with a=0xFF, b=0x00 during SHIFT → ignored; result is `diff`=0x0F. Hold `start` high in the DONE cycle with new operands → next `done` exactly 9 cycles later with the correct new result.
- Assert `rst_n`=0 at the 4th SHIFT cycle → `busy`/`done`/`diff`/`borrow_out` are 0 immediately, and no `done` follows. After release, a fresh 0x03-0x05 → `diff`=0xFE, `borrow_out`=1.
